// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    // 50 MHz / (2 * 165) = 16 x 9600 baud (approximately)
    localparam int unsigned CLK_DIV_DEFAULT = 165;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACK     = 2'd2
    } rx_state_e;

endpackage

// File: rtl/uart_rx_controller_if.sv
// Receiver-side and host-side signals of the UART receive controller.
interface uart_rx_controller_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8
);
    logic                          rx_clk;
    logic [DATA_W-1:0]             rx_data;
    logic                          rx_complete_flag;
    logic                          rx_complete_del_flag;
    logic                          rd_en;
    logic [DATA_W-1:0]             rd_data;
    logic                          fifo_empty;
    logic                          fifo_full;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overrun;
    logic                          overrun_clr;

    modport slave (
        input  rx_data, rx_complete_flag, rd_en, overrun_clr,
        output rx_clk, rx_complete_del_flag, rd_data, fifo_empty, fifo_full,
               fifo_count, overrun
    );

    modport master (
        output rx_data, rx_complete_flag, rd_en, overrun_clr,
        input  rx_clk, rx_complete_del_flag, rd_data, fifo_empty, fifo_full,
               fifo_count, overrun
    );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered head, count, full and empty.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_inc_c;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             full_q, empty_q;
    logic             push_ok_c, pop_ok_c;

    // A push into a full FIFO is legal only when a pop frees a slot the same cycle.
    assign push_ok_c    = push_i && (!full_q || pop_i);
    assign pop_ok_c     = pop_i && !empty_q;
    assign rd_ptr_inc_c = rd_ptr_q + PTR_W'(1);

    always_comb begin
        count_d = count_q;
        rdata_d = rdata_q;
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Next head: the entry behind the popped one, or the incoming byte.
        if (pop_ok_c) begin
            if (count_q > CNT_W'(1)) begin
                rdata_d = mem_q[rd_ptr_inc_c];
            end else if (push_ok_c) begin
                rdata_d = wdata_i;
            end
        end else if (push_ok_c && empty_q) begin
            rdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok_c)  rd_ptr_q <= rd_ptr_inc_c;
            count_q <= count_d;
            rdata_q <= rdata_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == CNT_W'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = rdata_q;
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_rx_controller.sv
// Drives the Receiver's rx_clk, captures completed bytes into a FIFO and
// acknowledges each one through the complete/delete flag handshake.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned DATA_W     = UART_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_rx_controller_if.slave  bus
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DIV_W-1:0] div_cnt_q;
    logic             rx_clk_q;
    logic [1:0]       sync_q;
    logic             flag_s;
    rx_state_e        state_q, state_d;
    logic             push_c, overrun_set_c, del_d;
    logic             del_q, overrun_q;
    logic             fifo_full_w, fifo_empty_w;
    logic [DATA_W-1:0] fifo_rdata_w;
    logic [CNT_W-1:0] fifo_count_w;

    // rx_clk divider: toggle on every counter wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            rx_clk_q  <= 1'b0;
        end else if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
            div_cnt_q <= '0;
            rx_clk_q  <= ~rx_clk_q;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // The completion flag originates in the rx_clk domain.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], bus.rx_complete_flag};
    end
    assign flag_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (flag_s) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_ACK;
            ST_ACK:     if (!flag_s) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // A full FIFO still accepts the byte when the host pops in the same cycle.
    always_comb begin
        push_c        = 1'b0;
        overrun_set_c = 1'b0;
        del_d         = (state_d == ST_ACK);
        if (state_q == ST_CAPTURE) begin
            if (!fifo_full_w || bus.rd_en) push_c = 1'b1;
            else                           overrun_set_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            del_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            del_q <= del_d;
            if (overrun_set_c)        overrun_q <= 1'b1;
            else if (bus.overrun_clr) overrun_q <= 1'b0;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .wdata_i (bus.rx_data),
        .pop_i   (bus.rd_en),
        .rdata_o (fifo_rdata_w),
        .count_o (fifo_count_w),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty_w)
    );

    assign bus.rx_clk               = rx_clk_q;
    assign bus.rx_complete_del_flag = del_q;
    assign bus.overrun              = overrun_q;
    assign bus.rd_data              = fifo_rdata_w;
    assign bus.fifo_count           = fifo_count_w;
    assign bus.fifo_full            = fifo_full_w;
    assign bus.fifo_empty           = fifo_empty_w;

endmodule
